// File: rtl/zbt_pix_writer_pkg.sv
// Shared definitions for the ZBT pixel writer.
// Holds the pixel field widths, the bus widths of the upstream/ZBT
// interfaces and the 2-bit capture FSM state encoding.
package zbt_pix_writer_pkg;

  localparam int CH_W   = 6;   // one colour channel
  localparam int PIX_W  = 18;  // {r6,g6,b6}
  localparam int PAIR_W = 36;  // {pixA, pixB}
  localparam int ADDR_W = 19;  // ZBT bank address
  localparam int H_W    = 11;  // hcount width
  localparam int V_W    = 10;  // vcount width

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/zbt_pix_writer_gray.sv
// Combinational luminance for one 18-bit pixel.
// Ports:
//   pix_i : {r6,g6,b6} pixel
//   y_o   : 6-bit luminance, (2r + 5g + b) >> 3
// The weighted sum peaks at 8*63 = 504, so 9 bits never overflow.
module pix_gray
  import zbt_pix_writer_pkg::*;
(
  input  logic [PIX_W-1:0] pix_i,
  output logic [CH_W-1:0]  y_o
);

  logic [CH_W-1:0] r_s;
  logic [CH_W-1:0] g_s;
  logic [CH_W-1:0] b_s;
  logic [8:0]      sum_s;

  assign r_s = pix_i[17:12];
  assign g_s = pix_i[11:6];
  assign b_s = pix_i[5:0];

  // 5g is built as 4g + g so no multiplier is needed
  assign sum_s = {2'b00, r_s, 1'b0}
               + {3'b000, g_s} + {1'b0, g_s, 2'b00}
               + {3'b000, b_s};

  assign y_o = sum_s[8:3];

endmodule

// File: rtl/zbt_pix_writer.sv
// Single-frame / continuous frame grabber writing pixel pairs to ZBT bank 1.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   hcount, vcount      : upstream raster counters
//   two_pixel_data      : upstream pixel pair {pixA, pixB}
//   write_addr1         : upstream ZBT address for the pair (leads data)
//   capture, continuous : one-frame request / keep re-arming
//   vram_write_addr/data, vram_we : ZBT bank-1 write port
//   busy                : armed or writing
//   frame_done          : one-cycle pulse at frame completion
// Upstream data lags its address by ADDR_DELAY cycles, so address and
// raster position go through an ADDR_DELAY-deep chain while data is only
// registered once; both land on the output on the same edge.
module zbt_pix_writer
  import zbt_pix_writer_pkg::*;
#(
  parameter int H_ACTIVE   = 1024,
  parameter int V_ACTIVE   = 768,
  parameter int ADDR_DELAY = 2,
  parameter int GRAY       = 1
)(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [H_W-1:0]    hcount,
  input  logic [V_W-1:0]    vcount,
  input  logic [PAIR_W-1:0] two_pixel_data,
  input  logic [ADDR_W-1:0] write_addr1,
  input  logic              capture,
  input  logic              continuous,
  output logic [ADDR_W-1:0] vram_write_addr,
  output logic [PAIR_W-1:0] vram_write_data,
  output logic              vram_we,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [H_W-1:0] H_LIM = H_W'(H_ACTIVE);
  localparam logic [V_W-1:0] V_LIM = V_W'(V_ACTIVE);

  logic [ADDR_W-1:0] addr_q [ADDR_DELAY];
  logic [H_W-1:0]    h_q    [ADDR_DELAY];
  logic [V_W-1:0]    v_q    [ADDR_DELAY];

  logic [ADDR_W-1:0] d_addr;
  logic [H_W-1:0]    d_h;
  logic [V_W-1:0]    d_v;

  logic [PAIR_W-1:0] conv_s;
  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic              we_d;

  logic [ADDR_W-1:0] waddr_q;
  logic [PAIR_W-1:0] wdata_q;
  logic              we_q;
  logic              busy_q;
  logic              done_q;

  // address / raster delay chain aligning position with lagging pixel data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ADDR_DELAY; i++) begin
        addr_q[i] <= '0;
        h_q[i]    <= '0;
        v_q[i]    <= '0;
      end
    end else begin
      addr_q[0] <= write_addr1;
      h_q[0]    <= hcount;
      v_q[0]    <= vcount;
      for (int i = 1; i < ADDR_DELAY; i++) begin
        addr_q[i] <= addr_q[i-1];
        h_q[i]    <= h_q[i-1];
        v_q[i]    <= v_q[i-1];
      end
    end
  end

  assign d_addr = addr_q[ADDR_DELAY-1];
  assign d_h    = h_q[ADDR_DELAY-1];
  assign d_v    = v_q[ADDR_DELAY-1];

  generate
    if (GRAY != 0) begin : g_gray
      logic [CH_W-1:0] ya_s;
      logic [CH_W-1:0] yb_s;

      pix_gray u_gray_a (.pix_i(two_pixel_data[35:18]), .y_o(ya_s));
      pix_gray u_gray_b (.pix_i(two_pixel_data[17:0]),  .y_o(yb_s));

      assign conv_s = {ya_s, ya_s, ya_s, yb_s, yb_s, yb_s};
    end else begin : g_pass
      assign conv_s = two_pixel_data;
    end
  endgenerate

  // capture FSM next state; a new capture is only looked at in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (capture || continuous) state_d = ST_ARMED;
        else                       state_d = ST_IDLE;
      end
      ST_ARMED: begin
        if (d_h == '0 && d_v == '0) state_d = ST_WRITE;
        else                        state_d = ST_ARMED;
      end
      ST_WRITE: begin
        // only the first line past the active area ends the frame, so a
        // counter wrap back to line 0 cannot end it early
        if (d_h == '0 && d_v == V_LIM) state_d = ST_DONE;
        else                           state_d = ST_WRITE;
      end
      ST_DONE: begin
        if (continuous) state_d = ST_ARMED;
        else            state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // one write per pair: the odd pixel position completes the pair
  assign we_d = (state_q == ST_WRITE) && d_h[0] && (d_h < H_LIM) && (d_v < V_LIM);

  // state and registered write-port / status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      waddr_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      waddr_q <= d_addr;
      wdata_q <= conv_s;
      we_q    <= we_d;
      busy_q  <= (state_d == ST_ARMED) || (state_d == ST_WRITE);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign vram_write_addr = waddr_q;
  assign vram_write_data = wdata_q;
  assign vram_we         = we_q;
  assign busy            = busy_q;
  assign frame_done      = done_q;

endmodule

// File: doc/zbt_pix_writer.md
ZBT_PIX_WRITER -- requirements
Module: zbt_pix_writer

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1024: active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 768: active lines per frame.
REQ-003 SHALL have parameter ADDR_DELAY, default 2: cycles that upstream pixel data lags its address.
REQ-004 SHALL have parameter GRAY, default 1: 1 = luminance conversion, 0 = pass-through.
REQ-005 SHALL have port clk, input, 1: sole clock.
REQ-006 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port hcount, input, 11: upstream horizontal counter.
REQ-008 SHALL have port vcount, input, 10: upstream vertical counter.
REQ-009 SHALL have port two_pixel_data, input, 36: upstream pixel pair, {pixA[35:18], pixB[17:0]}, each pixel {r6,g6,b6}.
REQ-010 SHALL have port write_addr1, input, 19: upstream ZBT bank-1 address for the pair.
REQ-011 SHALL have port capture, input, 1: single-frame request, sampled every cycle.
REQ-012 SHALL have port continuous, input, 1: re-arm after every frame while high.
REQ-013 SHALL have port vram_write_addr, output, 19: ZBT bank-1 write address.
REQ-014 SHALL have port vram_write_data, output, 36: ZBT bank-1 write data.
REQ-015 SHALL have port vram_we, output, 1: write strobe, one cycle per pair.
REQ-016 SHALL have port busy, output, 1: high in ARMED or WRITE.
REQ-017 SHALL have port frame_done, output, 1: one-cycle pulse at frame completion.

Function
REQ-018 SHALL delay write_addr1, hcount and vcount through an ADDR_DELAY-deep register chain (d_addr, d_h, d_v).
REQ-019 SHALL register vram_write_addr <= d_addr and vram_write_data <= conv(two_pixel_data) on the same edge; total address latency ADDR_DELAY+1, data latency 1.
REQ-020 With GRAY=1, SHALL compute per pixel y = (2r + 5g + b) >> 3 (9-bit sum, 6-bit result, no overflow) and output {y,y,y}.
REQ-021 With GRAY=0, SHALL pass two_pixel_data unchanged.
REQ-022 SHALL register vram_we <= 1 only when state == WRITE, d_h[0] == 1, d_h < H_ACTIVE and d_v < V_ACTIVE; otherwise 0.
REQ-023 SHALL implement FSM states IDLE, ARMED, WRITE, DONE.
REQ-024 IDLE -> ARMED when capture == 1 or continuous == 1.
REQ-025 ARMED -> WRITE when d_h == 0 and d_v == 0 (frame start); no writes in ARMED.
REQ-026 WRITE -> DONE when d_h == 0 and d_v == V_ACTIVE.
REQ-027 DONE lasts exactly one cycle and SHALL assert frame_done; DONE -> ARMED if continuous == 1, else IDLE.
REQ-028 capture during ARMED, WRITE or DONE SHALL be ignored (no queuing).
REQ-029 continuous dropping during WRITE SHALL let the current frame finish, then go to IDLE.
REQ-030 Counter wrap (d_v returning to 0 without reaching V_ACTIVE) in WRITE SHALL NOT end the frame early.
REQ-031 At most one vram_we per pair, i.e. H_ACTIVE/2 writes per active line.

Reset
REQ-032 While reset_n == 0: state IDLE; vram_we, busy and frame_done 0; vram_write_addr, vram_write_data and all delay registers 0.
REQ-033 Reset asserted mid-frame SHALL drop vram_we asynchronously; after release, no writes until a new capture or continuous request plus a frame start.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding (2 bits) and the pixel field widths (6-bit channel, 18-bit pixel, 36-bit pair).
REQ-035 Luminance conversion SHALL be one sub-module, pix_gray, instantiated twice (one instance per pixel), purely combinational.

Verification
REQ-036 GRAY=1, pixel {63,63,63} -> y = 63, word 0xFFFFFFFFF; pixel {8,0,0} -> y = 2.
REQ-037 capture pulse at vcount 100 -> ARMED until frame start, then exactly 512*768 vram_we pulses, frame_done once, then IDLE.
REQ-038 write_addr1 = 0x00123 at cycle t -> vram_write_addr = 0x00123 at cycle t+ADDR_DELAY+1 (t+3 by default).
REQ-039 continuous = 1 for two frames -> two frame_done pulses one frame apart; busy stays 1 except the DONE cycle.
REQ-040 reset_n low at line 300 of WRITE -> vram_we 0 immediately, state IDLE; no writes after release without a new capture.
REQ-041 capture re-pulsed during WRITE -> exactly one frame written, single frame_done.
